// File: rtl/uart_tx_serializer.sv
// UART transmit engine: one word per valid/ready handshake, sent as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        clk_cnt, clk_cnt_d;
    logic [2:0]           bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 par, par_d;
    logic                 fin, fin_q;
    logic                 bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state;
        clk_cnt_d = clk_cnt;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        par_d     = par;
        fin       = 1'b0;
        if (state != S_IDLE)
            clk_cnt_d = bit_end ? '0 : clk_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_d   = tx_data;
                    par_d     = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        fin       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line outputs follow the state one cycle later, so the start bit
    // falls on the edge after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            fin_q    <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            clk_cnt  <= clk_cnt_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            par      <= par_d;
            fin_q    <= fin;
            tx_done  <= fin_q;
            tx_ready <= (state == S_IDLE);
            tx_busy  <= (state != S_IDLE);
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shreg[0];
                S_PAR:   tx <= par;
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: four serializer configurations, expected line
// bits queued at acceptance and compared cycle by cycle on the tx pin.
module tb_uart_tx_serializer;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld [4];
    logic [7:0] data = 8'h00;
    logic       txv [4];
    logic       rdyv [4];
    logic       busyv [4];
    logic       donev [4];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   swap_at = -1;
    logic [7:0] swap_data = 8'h00;
    bit   hold = 1'b0;
    int   t_fall [$];
    logic sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(data),
        .tx_ready(rdyv[0]), .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(data),
        .tx_ready(rdyv[1]), .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(data),
        .tx_ready(rdyv[2]), .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(data[6:0]),
        .tx_ready(rdyv[3]), .tx(txv[3]), .tx_busy(busyv[3]), .tx_done(donev[3]));

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge with valid already raised; the next rising
    // edge is the acceptance edge.
    task automatic frame(int i, logic [7:0] w, int nd, int par, int ns);
        int   n;
        int   ones;
        logic pb;
        n    = 1 + nd + ((par != 0) ? 1 : 0) + ns;
        ones = 0;
        sb.push_back(1'b0);
        for (int b = 0; b < nd; b++) begin
            sb.push_back(w[b]);
            ones += int'(w[b]);
        end
        if (par != 0) begin
            pb = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
            sb.push_back(pb);
        end
        for (int s = 0; s < ns; s++) sb.push_back(1'b1);
        check("ready_pre", 32'(rdyv[i]), 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) vld[i] = 1'b0;
        check("tx_e0", 32'(txv[i]), 1);
        for (int j = 1; j <= n * C + 1; j++) begin
            @(negedge clk);
            if (j == swap_at) data = swap_data;
            if (j == 1) begin
                t_fall.push_back(cyc);
                check("busy_e1", 32'(busyv[i]), 1);
                check("ready_e1", 32'(rdyv[i]), 0);
            end
            if (j <= n * C) begin
                if (sb.size() > 0) begin
                    check($sformatf("tx_bit%0d", (j - 1) / C), 32'(txv[i]), 32'(sb[0]));
                    if (j % C == 0) void'(sb.pop_front());
                end
                if (j == n * C) begin
                    check("done_early", 32'(donev[i]), 0);
                    check("busy_end", 32'(busyv[i]), 1);
                end
            end else begin
                check("done", 32'(donev[i]), 1);
                check("ready_end", 32'(rdyv[i]), 1);
                check("busy_idle", 32'(busyv[i]), 0);
                check("tx_idle", 32'(txv[i]), 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        for (int k = 0; k < 4; k++) vld[k] = 1'b0;
        rst    = 1'b1;
        vld[0] = 1'b1;
        data   = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(txv[0]), 1);
            check("rst_ready", 32'(rdyv[0]), 1);
            check("rst_busy", 32'(busyv[0]), 0);
            check("rst_done", 32'(donev[0]), 0);
        end
        vld[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busyv[0]), 0);

        data = 8'h55; vld[0] = 1'b1;
        frame(0, 8'h55, 8, 0, 1);
        @(negedge clk);
        check("done_clear", 32'(donev[0]), 0);

        data = 8'h07; vld[1] = 1'b1;
        frame(1, 8'h07, 8, 1, 1);
        @(negedge clk);
        check("odd_done_clear", 32'(donev[1]), 0);

        data = 8'h07; vld[2] = 1'b1;
        frame(2, 8'h07, 8, 2, 1);

        data = 8'h7F; vld[3] = 1'b1;
        frame(3, 8'h7F, 7, 0, 2);

        hold = 1'b1; swap_at = 20; swap_data = 8'h3C;
        data = 8'hA5; vld[0] = 1'b1;
        frame(0, 8'hA5, 8, 0, 1);
        swap_at = -1; hold = 1'b0;
        frame(0, 8'h3C, 8, 0, 1);
        check("b2b_gap", 32'(t_fall[t_fall.size() - 1] - t_fall[t_fall.size() - 2]), 42);

        data = 8'hC3; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_rst_busy", 32'(busyv[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tx", 32'(txv[0]), 1);
        check("mrst_ready", 32'(rdyv[0]), 1);
        check("mrst_busy", 32'(busyv[0]), 0);
        rst = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            pulses += int'(donev[0]);
        end
        check("mrst_no_done", 32'(pulses), 0);

        data = 8'h96; vld[0] = 1'b1;
        frame(0, 8'h96, 8, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
